// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcode constants and the request-format encoding used by
// instr_encoder. The main decoder uses the same opcode constants.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // Codes 5..7 are not enumerated; anything outside this set is illegal.
    typedef enum logic [2:0] {
        FMT_LOAD   = 3'd0,
        FMT_STORE  = 3'd1,
        FMT_OP     = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_JAL    = 3'd4
    } fmt_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clear             synchronous flush (empties the FIFO)
//   push, din         write din when push && !full
//   pop               drop head when pop && !empty
//   dout              head word, forced to zero while empty
//   full, empty       occupancy flags from registered state
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is not reset; dout is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes LOAD/STORE/OP/BRANCH/JAL requests into RV32I words,
// buffers them in a FIFO and streams them out with a word address.
// Illegal requests are consumed, flagged on err for one cycle and counted.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   clear                      synchronous flush; keeps err_count
//   req_valid / req_ready      request handshake
//   req_fmt, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm
//                              request fields (imm is a signed byte offset)
//   out_valid / out_ready      output handshake
//   out_instr, out_addr        head word and its word address
//   err, err_count             rejection pulse and saturating count
module instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [20:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    logic [31:0]       enc_word;
    logic              legal;
    logic              fits12;
    logic              fits13;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] addr_q;

    // Sign-extension checks: upper bits must all equal the sign bit.
    assign fits12 = (req_imm[20:11] == '0) || (req_imm[20:11] == '1);
    assign fits13 = (req_imm[20:12] == '0) || (req_imm[20:12] == '1);

    always_comb begin
        enc_word = '0;
        legal    = 1'b0;
        case (fmt_e'(req_fmt))
            FMT_LOAD: begin
                enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
                legal    = fits12;
            end
            FMT_STORE: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:0], OP_STORE};
                legal    = fits12;
            end
            FMT_OP: begin
                enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
                legal    = 1'b1;
            end
            FMT_BRANCH: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], OP_BRANCH};
                legal    = fits13 && !req_imm[0];
            end
            FMT_JAL: begin
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OP_JAL};
                legal    = !req_imm[0];
            end
            default: begin
                enc_word = '0;
                legal    = 1'b0;
            end
        endcase
    end

    // A request offered during clear is dropped, neither pushed nor flagged.
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready && !clear;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready && !clear;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (enc_word),
        .dout  (out_instr),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            addr_q <= '0;
        end else if (pop) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err <= 1'b0;
        end else begin
            err <= accept && !legal;
        end
    end

    // Survives clear; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && !legal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        req_valid;
    logic [2:0]  req_fmt;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [20:0] req_imm;
    logic        out_ready;

    logic        req_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err;
    logic [7:0]  err_count;

    logic        req_ready2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;
    logic        err2;
    logic [7:0]  err_count2;

    int unsigned n_checks;
    int unsigned n_fail;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .err_count(err_count)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready2), .req_fmt(req_fmt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_addr(out_addr2), .err(err2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [20:0] imm);
        req_fmt = fmt; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_funct7 = f7; req_imm = imm; req_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        if (out_addr !== 8'd0) begin n_fail++; $display("FAIL reset_out_addr got %0d exp 0", out_addr); end
        if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    endtask

    task automatic test_op();
        do_reset();
        out_ready = 1'b1;
        set_req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
        tick();
        req_valid = 1'b0;
        n_checks += 4;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL op_valid got %b exp 1", out_valid); end
        if (out_instr !== 32'h002081B3) begin n_fail++; $display("FAIL op_instr got %h exp 002081b3", out_instr); end
        if (out_addr !== 8'd0) begin n_fail++; $display("FAIL op_addr got %0d exp 0", out_addr); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL op_err got %b exp 0", err); end
        tick();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL op_drained got %b exp 0", out_valid); end
        if (out_addr !== 8'd1) begin n_fail++; $display("FAIL op_addr_inc got %0d exp 1", out_addr); end
    endtask

    task automatic test_load_store();
        do_reset();
        out_ready = 1'b0;
        set_req(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 21'd8);
        tick();
        set_req(3'd1, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 21'd12);
        tick();
        req_valid = 1'b0;
        n_checks += 2;
        if (out_instr !== 32'h00812283) begin n_fail++; $display("FAIL load_instr got %h exp 00812283", out_instr); end
        if (out_addr !== 8'd0) begin n_fail++; $display("FAIL load_addr got %0d exp 0", out_addr); end
        out_ready = 1'b1;
        tick();
        n_checks += 2;
        if (out_instr !== 32'h00612623) begin n_fail++; $display("FAIL store_instr got %h exp 00612623", out_instr); end
        if (out_addr !== 8'd1) begin n_fail++; $display("FAIL store_addr got %0d exp 1", out_addr); end
        tick();
        n_checks += 1;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ls_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_branch_err();
        do_reset();
        out_ready = 1'b1;
        set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFF8);
        tick();
        req_valid = 1'b0;
        n_checks += 2;
        if (out_instr !== 32'hFE208CE3) begin n_fail++; $display("FAIL branch_instr got %h exp fe208ce3", out_instr); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL branch_err got %b exp 0", err); end
        tick();
        set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd3);
        tick();
        req_valid = 1'b0;
        n_checks += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL branch_odd_err got %b exp 1", err); end
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL branch_odd_cnt got %0d exp 1", err_count); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL branch_odd_valid got %b exp 0", out_valid); end
        tick();
        n_checks += 2;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got %b exp 0", err); end
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL err_cnt_hold got %0d exp 1", err_count); end
        set_req(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 21'd0);
        tick();
        req_valid = 1'b0;
        n_checks += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL fmt6_err got %b exp 1", err); end
        if (err_count !== 8'd2) begin n_fail++; $display("FAIL fmt6_cnt got %0d exp 2", err_count); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt6_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_boundaries();
        do_reset();
        out_ready = 1'b1;
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'h1FF800);
        tick();
        req_valid = 1'b0;
        n_checks += 2;
        if (out_instr !== 32'h80000003) begin n_fail++; $display("FAIL load_min_instr got %h exp 80000003", out_instr); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL load_min_err got %b exp 0", err); end
        tick();
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd2048);
        tick();
        req_valid = 1'b0;
        n_checks += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL load_2048_err got %b exp 1", err); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_2048_valid got %b exp 0", out_valid); end
        set_req(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'h1FFFFC);
        tick();
        req_valid = 1'b0;
        n_checks += 2;
        if (out_instr !== 32'hFFDFF06F) begin n_fail++; $display("FAIL jal_instr got %h exp ffdff06f", out_instr); end
        if (out_addr !== 8'd1) begin n_fail++; $display("FAIL jal_addr got %0d exp 1", out_addr); end
        tick();
        set_req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd1);
        tick();
        set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd4096);
        tick();
        req_valid = 1'b0;
        n_checks += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL branch_4096_err got %b exp 1", err); end
        if (err_count !== 8'd3) begin n_fail++; $display("FAIL boundary_cnt got %0d exp 3", err_count); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL boundary_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w;
        logic        will_acc;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(3'd2, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
            tick();
            n_checks++;
            if (req_ready !== (i < 3)) begin n_fail++; $display("FAIL bp_ready_%0d got %b exp %b", i, req_ready, (i < 3)); end
        end
        set_req(3'd2, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
        tick();
        tick();
        n_checks += 3;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold got %b exp 0", req_ready); end
        if (out_instr !== 32'h002080B3) begin n_fail++; $display("FAIL bp_stable_instr got %h exp 002080b3", out_instr); end
        if (out_addr !== 8'd0) begin n_fail++; $display("FAIL bp_stable_addr got %0d exp 0", out_addr); end
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_w = 32'h00208033 | (32'(j + 1) << 7);
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d got %b exp 1", j, out_valid); end
            if (out_instr !== exp_w) begin n_fail++; $display("FAIL bp_word_%0d got %h exp %h", j, out_instr, exp_w); end
            if (out_addr !== 8'(j)) begin n_fail++; $display("FAIL bp_addr_%0d got %0d exp %0d", j, out_addr, j); end
            will_acc = req_valid && req_ready;
            tick();
            if (will_acc) req_valid = 1'b0;
        end
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b exp 0", out_valid); end
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_fifth_accepted got %b exp 0", req_valid); end
        if (out_addr !== 8'd5) begin n_fail++; $display("FAIL bp_final_addr got %0d exp 5", out_addr); end
        req_valid = 1'b0;
    endtask

    task automatic test_addr_wrap();
        logic [31:0] exp_w;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_w = 32'h00208033 | (32'(i + 1) << 7);
            set_req(3'd2, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
            tick();
            req_valid = 1'b0;
            n_checks += 4;
            if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid_%0d got %b exp 1", i, out_valid2); end
            if (out_instr2 !== exp_w) begin n_fail++; $display("FAIL wrap_word_%0d got %h exp %h", i, out_instr2, exp_w); end
            if (out_addr2 !== 2'(i % 4)) begin n_fail++; $display("FAIL wrap_addr_%0d got %0d exp %0d", i, out_addr2, i % 4); end
            if (out_addr !== 8'(i)) begin n_fail++; $display("FAIL nowrap_addr_%0d got %0d exp %0d", i, out_addr, i); end
            tick();
        end
    endtask

    task automatic test_clear();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(3'd2, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
            tick();
        end
        set_req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0);
        tick();
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks += 2;
        if (out_addr !== 8'd1) begin n_fail++; $display("FAIL pre_clear_addr got %0d exp 1", out_addr); end
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL pre_clear_cnt got %0d exp 1", err_count); end
        clear = 1'b1;
        set_req(3'd2, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
        tick();
        clear = 1'b0;
        req_valid = 1'b0;
        n_checks += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %b exp 0", out_valid); end
        if (out_addr !== 8'd0) begin n_fail++; $display("FAIL clear_addr got %0d exp 0", out_addr); end
        if (out_instr !== 32'h0) begin n_fail++; $display("FAIL clear_instr got %h exp 0", out_instr); end
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL clear_keeps_cnt got %0d exp 1", err_count); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready got %b exp 1", req_ready); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL clear_err got %b exp 0", err); end
        clear = 1'b1;
        set_req(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0);
        tick();
        clear = 1'b0;
        req_valid = 1'b0;
        n_checks += 3;
        if (err !== 1'b0) begin n_fail++; $display("FAIL clear_drop_err got %b exp 0", err); end
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL clear_drop_cnt got %0d exp 1", err_count); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_drop_valid got %b exp 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            set_req(3'd2, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
            tick();
        end
        set_req(3'd2, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
        do_reset();
        req_valid = 1'b0;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        if (out_addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr got %0d exp 0", out_addr); end
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", err_count); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_fmt = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_funct7 = '0; req_imm = '0;
        tick();
        test_reset();
        test_op();
        test_load_store();
        test_branch_err();
        test_boundaries();
        test_backpressure();
        test_addr_wrap();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
